bank_cmd_scheduler: RTL and testbench

In-order DDRx command sequencer between the address mapper and the PHY command path. Takes one mapped request at a time (rank, bank, row, column, direction) and tracks the open row of every rank/bank. Issues PRE/ACT/RD/WR with open-page policy and enforces tRCD/tRP/tRAS/tRFC with down-counters. Services periodic refresh with precharge-all followed by REF.

---
 rtl/bank_cmd_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_bank_cmd_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_scheduler.sv
// In-order DDRx command sequencer: open-row tracking per rank/bank, PRE/ACT/RD/WR/PREA/REF issue.
// Define MC_AUTO_PRECHARGE_EN for closed-page policy (RD/WR with auto-precharge).
module bank_cmd_scheduler #(
    parameter int unsigned C_CS_WIDTH   = 1,
    parameter int unsigned C_BANK_WIDTH = 3,
    parameter int unsigned C_ROW_WIDTH  = 16,
    parameter int unsigned T_RCD        = 4,
    parameter int unsigned T_RP         = 4,
    parameter int unsigned T_RAS        = 10,
    parameter int unsigned T_RFC        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [C_CS_WIDTH-1:0]   req_rank,
    input  logic [C_BANK_WIDTH-1:0] req_bank,
    input  logic [C_ROW_WIDTH-1:0]  req_row,
    input  logic [11:0]             req_column,
    input  logic                    ref_req,
    output logic                    ref_ack,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [2:0]              cmd_type,
    output logic [C_CS_WIDTH-1:0]   cmd_rank,
    output logic [C_BANK_WIDTH-1:0] cmd_bank,
    output logic [C_ROW_WIDTH-1:0]  cmd_addr,
    output logic                    cmd_ap,
    output logic                    busy
);

    localparam int unsigned IdxW     = C_CS_WIDTH + C_BANK_WIDTH;
    localparam int unsigned NumBanks = 2 ** IdxW;
    localparam int unsigned CntW     = $clog2(T_RCD + T_RP + T_RAS + T_RFC + 1);

`ifdef MC_AUTO_PRECHARGE_EN
    localparam bit ApEn = 1'b1;
`else
    localparam bit ApEn = 1'b0;
`endif

    localparam logic [2:0] CmdNop  = 3'd0;
    localparam logic [2:0] CmdAct  = 3'd1;
    localparam logic [2:0] CmdRd   = 3'd2;
    localparam logic [2:0] CmdWr   = 3'd3;
    localparam logic [2:0] CmdPre  = 3'd4;
    localparam logic [2:0] CmdPrea = 3'd5;
    localparam logic [2:0] CmdRef  = 3'd6;

    localparam logic [CntW-1:0] LdRcd  = CntW'(T_RCD - 1);
    localparam logic [CntW-1:0] LdRp   = CntW'(T_RP - 1);
    localparam logic [CntW-1:0] LdRas  = CntW'(T_RAS - 1);
    localparam logic [CntW-1:0] LdRfc  = CntW'(T_RFC - 1);
    // Implicit precharge after an auto-precharged column command must also cover tRAS.
    localparam logic [CntW-1:0] LdRpAp = CntW'(T_RP + T_RAS - 1);

    typedef enum logic [2:0] {
        StIdle, StDecide, StPre, StAct, StRw, StPrea, StRef, StRfcWait
    } state_e;

    state_e                  r_state;
    logic [NumBanks-1:0]     r_open;
    logic [C_ROW_WIDTH-1:0]  r_row [NumBanks];
    logic [CntW-1:0]         r_rcd_cnt, r_rp_cnt, r_ras_cnt, r_rfc_cnt;
    logic                    r_cmd_valid;
    logic [2:0]              r_cmd_type;
    logic [C_CS_WIDTH-1:0]   r_cmd_rank;
    logic [C_BANK_WIDTH-1:0] r_cmd_bank;
    logic [C_ROW_WIDTH-1:0]  r_cmd_addr;
    logic                    r_cmd_ap;

    logic [IdxW-1:0]         w_idx;
    logic                    w_accept;
    logic [CntW-1:0]         w_rcd_dec, w_rp_dec, w_ras_dec, w_rfc_dec;
    logic [2:0]              w_rw_type;
    logic [C_ROW_WIDTH-1:0]  w_col_addr;
    logic                    w_hit;

    assign w_idx      = {req_rank, req_bank};
    assign w_accept   = r_cmd_valid && cmd_ready;
    assign w_rcd_dec  = (r_rcd_cnt != '0) ? r_rcd_cnt - 1'b1 : '0;
    assign w_rp_dec   = (r_rp_cnt  != '0) ? r_rp_cnt  - 1'b1 : '0;
    assign w_ras_dec  = (r_ras_cnt != '0) ? r_ras_cnt - 1'b1 : '0;
    assign w_rfc_dec  = (r_rfc_cnt != '0) ? r_rfc_cnt - 1'b1 : '0;
    assign w_rw_type  = req_write ? CmdWr : CmdRd;
    assign w_col_addr = C_ROW_WIDTH'(req_column);
    assign w_hit      = r_open[w_idx] && (r_row[w_idx] == req_row);

    // cmd_valid is set one cycle ahead from the decremented counter, so the dependent
    // command is presented in exactly the first cycle its counter reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_open      <= '0;
            r_rcd_cnt   <= '0;
            r_rp_cnt    <= '0;
            r_ras_cnt   <= '0;
            r_rfc_cnt   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= CmdNop;
            r_cmd_rank  <= '0;
            r_cmd_bank  <= '0;
            r_cmd_addr  <= '0;
            r_cmd_ap    <= 1'b0;
        end else begin
            r_rcd_cnt <= w_rcd_dec;
            r_rp_cnt  <= w_rp_dec;
            r_ras_cnt <= w_ras_dec;
            r_rfc_cnt <= w_rfc_dec;
            unique case (r_state)
                StIdle: begin
                    if (ref_req) begin
                        r_cmd_rank <= '0;
                        r_cmd_bank <= '0;
                        r_cmd_addr <= '0;
                        r_cmd_ap   <= 1'b0;
                        if (|r_open) begin
                            r_state     <= StPrea;
                            r_cmd_type  <= CmdPrea;
                            r_cmd_valid <= (w_ras_dec == '0);
                        end else begin
                            r_state     <= StRef;
                            r_cmd_type  <= CmdRef;
                            r_cmd_valid <= (w_rp_dec == '0);
                        end
                    end else if (req_valid) begin
                        r_state <= StDecide;
                    end
                end
                StDecide: begin
                    r_cmd_rank <= req_rank;
                    r_cmd_bank <= req_bank;
                    if (w_hit) begin
                        r_state     <= StRw;
                        r_cmd_type  <= w_rw_type;
                        r_cmd_addr  <= w_col_addr;
                        r_cmd_ap    <= ApEn;
                        r_cmd_valid <= (w_rcd_dec == '0);
                    end else if (r_open[w_idx]) begin
                        r_state     <= StPre;
                        r_cmd_type  <= CmdPre;
                        r_cmd_addr  <= '0;
                        r_cmd_ap    <= 1'b0;
                        r_cmd_valid <= (w_ras_dec == '0);
                    end else begin
                        r_state     <= StAct;
                        r_cmd_type  <= CmdAct;
                        r_cmd_addr  <= req_row;
                        r_cmd_ap    <= 1'b0;
                        r_cmd_valid <= (w_rp_dec == '0);
                    end
                end
                StPre: begin
                    if (!r_cmd_valid) begin
                        r_cmd_valid <= (w_ras_dec == '0);
                    end else if (cmd_ready) begin
                        r_open[w_idx] <= 1'b0;
                        r_rp_cnt      <= LdRp;
                        r_state       <= StAct;
                        r_cmd_type    <= CmdAct;
                        r_cmd_addr    <= req_row;
                        r_cmd_valid   <= (LdRp == '0);
                    end
                end
                StAct: begin
                    if (!r_cmd_valid) begin
                        r_cmd_valid <= (w_rp_dec == '0);
                    end else if (cmd_ready) begin
                        r_open[w_idx] <= 1'b1;
                        r_row[w_idx]  <= req_row;
                        r_rcd_cnt     <= LdRcd;
                        r_ras_cnt     <= LdRas;
                        r_state       <= StRw;
                        r_cmd_type    <= w_rw_type;
                        r_cmd_addr    <= w_col_addr;
                        r_cmd_ap      <= ApEn;
                        r_cmd_valid   <= (LdRcd == '0);
                    end
                end
                StRw: begin
                    if (!r_cmd_valid) begin
                        r_cmd_valid <= (w_rcd_dec == '0);
                    end else if (cmd_ready) begin
                        if (ApEn) begin
                            r_open[w_idx] <= 1'b0;
                            r_rp_cnt      <= LdRpAp;
                        end
                        r_state     <= StIdle;
                        r_cmd_valid <= 1'b0;
                        r_cmd_type  <= CmdNop;
                        r_cmd_rank  <= '0;
                        r_cmd_bank  <= '0;
                        r_cmd_addr  <= '0;
                        r_cmd_ap    <= 1'b0;
                    end
                end
                StPrea: begin
                    if (!r_cmd_valid) begin
                        r_cmd_valid <= (w_ras_dec == '0);
                    end else if (cmd_ready) begin
                        r_open      <= '0;
                        r_rp_cnt    <= LdRp;
                        r_state     <= StRef;
                        r_cmd_type  <= CmdRef;
                        r_cmd_valid <= (LdRp == '0);
                    end
                end
                StRef: begin
                    if (!r_cmd_valid) begin
                        r_cmd_valid <= (w_rp_dec == '0);
                    end else if (cmd_ready) begin
                        r_rfc_cnt   <= LdRfc;
                        r_state     <= StRfcWait;
                        r_cmd_type  <= CmdNop;
                        r_cmd_valid <= 1'b0;
                    end
                end
                StRfcWait: begin
                    if (r_rfc_cnt == '0) begin
                        r_state <= StIdle;
                    end
                end
            endcase
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_type  = r_cmd_type;
    assign cmd_rank  = r_cmd_rank;
    assign cmd_bank  = r_cmd_bank;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_ap    = r_cmd_ap;
    assign busy      = (r_state != StIdle);
    // A reset cycle must not retire the request or finish the refresh.
    assign req_ready = !rst && (r_state == StRw) && w_accept;
    assign ref_ack   = !rst && (r_state == StRfcWait) && (r_rfc_cnt == '0);

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Self-checking bench for bank_cmd_scheduler: vector table, corner sequences, random vs model.
module tb_bank_cmd_scheduler;

    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int T_RAS = 10;
    localparam int T_RFC = 32;
`ifdef MC_AUTO_PRECHARGE_EN
    localparam bit ApExp = 1'b1;
`else
    localparam bit ApExp = 1'b0;
`endif
    localparam logic [2:0] CNop = 3'd0, CAct = 3'd1, CRd = 3'd2, CWr = 3'd3;
    localparam logic [2:0] CPre = 3'd4, CPrea = 3'd5, CRef = 3'd6;

    typedef struct packed {
        logic [2:0]  t;
        logic        rk;
        logic [2:0]  bk;
        logic [15:0] addr;
    } cmd_t;

    typedef struct packed {
        bit             w;
        bit             rk;
        bit [2:0]       bk;
        bit [15:0]      row;
        bit [11:0]      col;
        bit             doref;
        int             n;
        logic [3:0][2:0] ts;
    } vec_t;

    logic clk, rst, req_valid, req_ready, req_write, req_rank;
    logic [2:0] req_bank;
    logic [15:0] req_row;
    logic [11:0] req_column;
    logic ref_req, ref_ack, cmd_valid, cmd_ready, cmd_rank, cmd_ap, busy;
    logic [2:0] cmd_type, cmd_bank;
    logic [15:0] cmd_addr;

    bank_cmd_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_rank(req_rank), .req_bank(req_bank), .req_row(req_row),
        .req_column(req_column), .ref_req(ref_req), .ref_ack(ref_ack),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_rank(cmd_rank), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_ap(cmd_ap),
        .busy(busy)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit exact = 0;
    bit rand_ready = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ge(input string name, input longint act, input longint lim);
        n_checks++;
        if (act < lim) begin
            n_fail++;
            $display("FAIL %s: got %0d, required at least %0d (cycle %0d)", name, act, lim, cyc);
        end
    endtask

    function automatic cmd_t mk(input logic [2:0] t, input logic rk, input logic [2:0] bk,
                                input logic [15:0] a);
        cmd_t c;
        c.t = t; c.rk = rk; c.bk = bk; c.addr = a;
        return c;
    endfunction

    // Bus monitor: logs accepted commands and checks DRAM timing rules in elapsed cycles.
    cmd_t acc_q[$];
    int last_act, last_pre, last_ref;
    logic [2:0] prev_t;
    bit have_stall;
    logic [23:0] stall_bus;

    always @(negedge clk) begin
        cmd_t c;
        bit acc, isrw;
        if (rst) begin
            last_act = -1000; last_pre = -1000; last_ref = -1000;
            prev_t = CNop; have_stall = 0;
        end else begin
            c = mk(cmd_type, cmd_rank, cmd_bank, cmd_addr);
            acc = cmd_valid && cmd_ready;
            isrw = (cmd_type == CRd) || (cmd_type == CWr);
            if (have_stall) check_eq("stall_hold", {cmd_valid, c, cmd_ap}, {1'b1, stall_bus});
            have_stall = cmd_valid && !cmd_ready;
            stall_bus = {c, cmd_ap};
            if (req_ready || (acc && isrw)) check_eq("req_ready", req_ready, acc && isrw);
            if (ref_ack) check_eq("tRFC", cyc - last_ref, T_RFC);
            if (acc) begin
                acc_q.push_back(c);
                if (c.t != CRef) check_ge("after_ref", cyc - last_ref, T_RFC + 1);
                check_eq("cmd_ap", cmd_ap, isrw ? ApExp : 1'b0);
                case (c.t)
                    CAct: begin
                        check_ge("tRP", cyc - last_pre, T_RP);
                        if (exact && prev_t == CPre) check_eq("tRP_exact", cyc - last_pre, T_RP);
                        last_act = cyc;
                    end
                    CRd, CWr: begin
                        check_ge("tRCD", cyc - last_act, T_RCD);
                        if (exact && prev_t == CAct) check_eq("tRCD_exact", cyc - last_act, T_RCD);
                        if (ApExp) last_pre = cyc + T_RAS;
                    end
                    CPre, CPrea: begin
                        check_ge("tRAS", cyc - last_act, T_RAS);
                        last_pre = cyc;
                    end
                    CRef: begin
                        check_ge("tRP_ref", cyc - last_pre, T_RP);
                        if (exact && prev_t == CPrea) check_eq("tRP_ref_exact", cyc - last_pre, T_RP);
                        last_ref = cyc;
                    end
                    default: check_eq("cmd_type_legal", c.t, CAct);
                endcase
                prev_t = c.t;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) cmd_ready = ($urandom_range(3) != 0);
    end

    // Reference model: open-row table per {rank, bank}, expected command list.
    bit m_open [16];
    logic [15:0] m_row [16];
    cmd_t exp_q[$];

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_open[i] = 0;
    endtask

    task automatic predict_req(input bit w, input bit rk, input bit [2:0] bk, input bit [15:0] row,
                               input bit [11:0] col);
        int idx;
        idx = rk * 8 + bk;
        if (!(m_open[idx] && m_row[idx] == row)) begin
            if (m_open[idx]) exp_q.push_back(mk(CPre, rk, bk, 16'h0));
            exp_q.push_back(mk(CAct, rk, bk, row));
            m_open[idx] = !ApExp;
            m_row[idx] = row;
        end
        exp_q.push_back(mk(w ? CWr : CRd, rk, bk, {4'h0, col}));
    endtask

    task automatic predict_ref();
        bit any = 0;
        for (int i = 0; i < 16; i++) any |= m_open[i];
        if (any) exp_q.push_back(mk(CPrea, 1'b0, 3'd0, 16'h0));
        exp_q.push_back(mk(CRef, 1'b0, 3'd0, 16'h0));
        model_clear();
    endtask

    task automatic compare_q(input string name);
        check_eq({name, "_count"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            if (exp_q[i].t == CPrea || exp_q[i].t == CRef)
                check_eq({name, "_type"}, acc_q[i].t, exp_q[i].t);
            else
                check_eq({name, "_cmd"}, acc_q[i], exp_q[i]);
        end
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic send_req(input bit w, input bit rk, input bit [2:0] bk, input bit [15:0] row,
                            input bit [11:0] col, input bit doref);
        int t = 0;
        bit got_ref = 0;
        req_write = w; req_rank = rk; req_bank = bk; req_row = row; req_column = col;
        req_valid = 1;
        ref_req = doref;
        while (t < 500) begin
            @(negedge clk);
            if (ref_ack) begin
                got_ref = 1;
                ref_req = 0;
            end
            if (req_ready) break;
            t++;
        end
        check_eq("req_done", t < 500, 1);
        if (doref) check_eq("ref_before_req", got_ref, 1);
        ref_req = 0;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic do_ref();
        int t = 0;
        ref_req = 1;
        while (t < 500) begin
            @(negedge clk);
            if (ref_ack) break;
            t++;
        end
        ref_req = 0;
        check_eq("ref_done", t < 500, 1);
        @(posedge clk); #1;
    endtask

    function automatic vec_t mkv(input bit w, input bit rk, input bit [2:0] bk, input bit [15:0] row,
                                 input bit [11:0] col, input bit doref, input int n,
                                 input logic [2:0] t0, input logic [2:0] t1,
                                 input logic [2:0] t2, input logic [2:0] t3);
        vec_t v;
        v.w = w; v.rk = rk; v.bk = bk; v.row = row; v.col = col; v.doref = doref; v.n = n;
        v.ts = {t3, t2, t1, t0};
        return v;
    endfunction

    vec_t vec [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit w, rk;
        bit [2:0] bk;
        bit [15:0] row;
        bit [11:0] col;
`ifdef MC_AUTO_PRECHARGE_EN
        vec[0] = mkv(0, 0, 2, 16'h0123, 12'h040, 0, 2, CAct, CRd, CNop, CNop);
        vec[1] = mkv(0, 0, 2, 16'h0123, 12'h080, 0, 2, CAct, CRd, CNop, CNop);
        vec[2] = mkv(1, 0, 2, 16'h0456, 12'h010, 0, 2, CAct, CWr, CNop, CNop);
        vec[3] = mkv(0, 0, 5, 16'h0077, 12'h001, 1, 3, CRef, CAct, CRd, CNop);
        vec[4] = mkv(1, 1, 5, 16'h0077, 12'h002, 0, 2, CAct, CWr, CNop, CNop);
        vec[5] = mkv(0, 1, 5, 16'h0077, 12'hfff, 0, 2, CAct, CRd, CNop, CNop);
        vec[6] = mkv(0, 0, 5, 16'hffff, 12'h000, 0, 2, CAct, CRd, CNop, CNop);
`else
        vec[0] = mkv(0, 0, 2, 16'h0123, 12'h040, 0, 2, CAct, CRd, CNop, CNop);
        vec[1] = mkv(0, 0, 2, 16'h0123, 12'h080, 0, 1, CRd, CNop, CNop, CNop);
        vec[2] = mkv(1, 0, 2, 16'h0456, 12'h010, 0, 3, CPre, CAct, CWr, CNop);
        vec[3] = mkv(0, 0, 5, 16'h0077, 12'h001, 1, 4, CPrea, CRef, CAct, CRd);
        vec[4] = mkv(1, 1, 5, 16'h0077, 12'h002, 0, 2, CAct, CWr, CNop, CNop);
        vec[5] = mkv(0, 1, 5, 16'h0077, 12'hfff, 0, 1, CRd, CNop, CNop, CNop);
        vec[6] = mkv(0, 0, 5, 16'hffff, 12'h000, 0, 3, CPre, CAct, CRd, CNop);
`endif
        rst = 1; req_valid = 0; req_write = 0; req_rank = 0; req_bank = 0; req_row = 0;
        req_column = 0; ref_req = 0; cmd_ready = 1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_outputs", {req_ready, ref_ack, cmd_valid, cmd_type, cmd_rank, cmd_bank,
                                   cmd_addr, cmd_ap, busy}, 0);
        @(posedge clk); #1;
        rst = 0;

        // Directed vectors with cmd_ready held high: exact latencies apply.
        exact = 1;
        for (int i = 0; i < 7; i++) begin
            send_req(vec[i].w, vec[i].rk, vec[i].bk, vec[i].row, vec[i].col, vec[i].doref);
            check_eq($sformatf("tbl%0d_n", i), acc_q.size(), vec[i].n);
            for (int k = 0; k < vec[i].n && k < acc_q.size(); k++) begin
                check_eq($sformatf("tbl%0d_t%0d", i, k), acc_q[k].t, vec[i].ts[k]);
                if (acc_q[k].t == CAct) check_eq($sformatf("tbl%0d_row", i), acc_q[k].addr, vec[i].row);
            end
            if (acc_q.size() > 0) check_eq($sformatf("tbl%0d_col", i), acc_q[$].addr, {4'h0, vec[i].col});
            acc_q.delete();
        end
        exact = 0;

        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        acc_q.delete();
        model_clear();

        // PHY stalls the ACT for 5 cycles; monitor checks the bus holds.
        cmd_ready = 0;
        predict_req(0, 0, 7, 16'h0003, 12'h005);
        req_write = 0; req_rank = 0; req_bank = 7; req_row = 16'h0003; req_column = 12'h005;
        req_valid = 1;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_valid && t < 50);
        check_eq("stall_valid", cmd_valid, 1);
        check_eq("stall_type", cmd_type, CAct);
        repeat (5) @(negedge clk);
        check_eq("stall_addr", cmd_addr, 16'h0003);
        cmd_ready = 1;
        send_req(0, 0, 7, 16'h0003, 12'h005, 0);
        compare_q("stall");

        // Reset during the tRCD wait: sequence aborts, table cleared, retry re-activates.
        req_write = 0; req_rank = 1; req_bank = 1; req_row = 16'h0055; req_column = 12'h009;
        req_valid = 1;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!(cmd_valid && cmd_ready && cmd_type == CAct) && t < 50);
        check_eq("rcd_act_seen", cmd_type, CAct);
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check_eq("rst_mid_rcd", {req_ready, ref_ack, cmd_valid, cmd_type, cmd_rank, cmd_bank,
                                 cmd_addr, cmd_ap, busy}, 0);
        acc_q.delete();
        model_clear();
        predict_req(0, 1, 1, 16'h0055, 12'h009);
        send_req(0, 1, 1, 16'h0055, 12'h009, 0);
        compare_q("rst_retry");
        predict_req(1, 0, 7, 16'h0003, 12'h006);
        send_req(1, 0, 7, 16'h0003, 12'h006, 0);
        compare_q("rst_cleared_bank");

        // Random traffic with random PHY backpressure.
        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(7) == 0) begin
                predict_ref();
                do_ref();
                compare_q("rand_ref");
            end
            w = 1'($urandom_range(1));
            rk = 1'($urandom_range(1));
            bk = 3'($urandom_range(3));
            row = 16'h0010 + 16'($urandom_range(1));
            col = 12'($urandom_range(4095));
            predict_req(w, rk, bk, row, col);
            send_req(w, rk, bk, row, col, 0);
            compare_q("rand_req");
        end
        rand_ready = 0;
        @(posedge clk); #1;
        cmd_ready = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
